// File: rtl/vga_sync_rx.sv
// VGA timing receiver: recovers line/frame timing, pixel coordinates and a lock/err status from sync pins.
// Latency: pixel pins to pix_valid 2 clocks, vsync fall to frame_start 2 clocks; no backpressure, runs at the pixel rate.
module vga_sync_rx #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank_b,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic        frame_start,
  output logic [9:0]  line_len,
  output logic [9:0]  frame_lines,
  output logic        locked,
  output logic        err
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_WAIT_VS = 2'd1;
  localparam logic [1:0] ST_TRACK   = 2'd2;
  localparam logic [1:0] ST_LOCKED  = 2'd3;

  localparam logic [9:0] CNT_MAX = 10'h3FF;
  localparam logic [9:0] H_TOT   = 10'(H_TOTAL);
  localparam logic [9:0] V_TOT   = 10'(V_TOTAL);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [7:0] LOCK_N  = 8'(LOCK_FRAMES);

  logic        hs_q, vs_q, hs_d, vs_d;
  logic        blank_q;
  logic [23:0] rgb_q;
  logic        hs_fall, vs_fall;

  logic [9:0]  hcnt, vcnt;
  logic [9:0]  x_cnt, y_cnt;
  logic        line_act;
  logic [9:0]  len_new, lines_new;

  logic [1:0]  state;
  logic [7:0]  good_cnt;
  logic [7:0]  good_nxt;
  logic        line_bad;
  logic        len_bad;
  logic        frame_ok;
  logic        lock_fault;

  // Sync copies reset high so releasing reset never looks like a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      hs_d    <= 1'b1;
      vs_d    <= 1'b1;
      blank_q <= 1'b0;
      rgb_q   <= 24'h0;
    end else begin
      hs_q    <= hsync;
      vs_q    <= vsync;
      hs_d    <= hs_q;
      vs_d    <= vs_q;
      blank_q <= blank_b;
      rgb_q   <= {r, g, b};
    end
  end

  assign hs_fall = hs_d & ~hs_q;
  assign vs_fall = vs_d & ~vs_q;

  assign len_new   = (hcnt == CNT_MAX) ? CNT_MAX : hcnt + 10'd1;
  // A coinciding hsync closes the last line of the ending frame, so it is counted before the snapshot.
  assign lines_new = !hs_fall ? vcnt : ((vcnt == CNT_MAX) ? CNT_MAX : vcnt + 10'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt     <= 10'd0;
      line_len <= 10'd0;
    end else if (hs_fall) begin
      hcnt     <= 10'd0;
      line_len <= len_new;
    end else if (hcnt != CNT_MAX) begin
      hcnt     <= hcnt + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vcnt        <= 10'd0;
      frame_lines <= 10'd0;
    end else if (vs_fall) begin
      vcnt        <= 10'd0;
      frame_lines <= lines_new;
    end else if (hs_fall && vcnt != CNT_MAX) begin
      vcnt        <= vcnt + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_cnt    <= 10'd0;
      y_cnt    <= 10'd0;
      line_act <= 1'b0;
    end else begin
      if (hs_fall) begin
        x_cnt <= 10'd0;
      end else if (blank_q && x_cnt != CNT_MAX) begin
        x_cnt <= x_cnt + 10'd1;
      end

      if (hs_fall) begin
        line_act <= 1'b0;
      end else if (blank_q) begin
        line_act <= 1'b1;
      end

      if (vs_fall) begin
        y_cnt <= 10'd0;
      end else if (hs_fall && line_act && y_cnt != CNT_MAX) begin
        y_cnt <= y_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_valid   <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      pix_rgb     <= 24'h0;
      frame_start <= 1'b0;
    end else begin
      pix_valid   <= blank_q;
      frame_start <= vs_fall;
      if (blank_q) begin
        pix_x   <= x_cnt;
        pix_y   <= y_cnt;
        pix_rgb <= rgb_q;
      end
    end
  end

  assign len_bad  = hs_fall && (len_new != H_TOT);
  assign frame_ok = !line_bad && !len_bad && (lines_new == V_TOT);
  assign good_nxt = good_cnt + 8'd1;
  // Pixel/line counts are compared as counts, so a full active line (count == H_ACTIVE) is legal.
  assign lock_fault = len_bad || (vs_fall && lines_new != V_TOT) ||
                      (x_cnt > H_ACT) || (y_cnt > V_ACT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_bad <= 1'b0;
    end else if (vs_fall) begin
      line_bad <= 1'b0;
    end else if (len_bad) begin
      line_bad <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_SEARCH;
      good_cnt <= 8'd0;
      err      <= 1'b0;
    end else begin
      case (state)
        ST_SEARCH: begin
          good_cnt <= 8'd0;
          if (hs_fall) begin
            state <= vs_fall ? ST_TRACK : ST_WAIT_VS;
          end
        end
        ST_WAIT_VS: begin
          good_cnt <= 8'd0;
          if (vs_fall) begin
            state <= ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (vs_fall) begin
            if (!frame_ok) begin
              good_cnt <= 8'd0;
            end else if (good_nxt >= LOCK_N) begin
              good_cnt <= 8'd0;
              state    <= ST_LOCKED;
            end else begin
              good_cnt <= good_nxt;
            end
          end
        end
        ST_LOCKED: begin
          if (lock_fault) begin
            err   <= 1'b1;
            state <= ST_SEARCH;
          end
        end
        default: state <= ST_SEARCH;
      endcase
    end
  end

  assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_vga_sync_rx.sv
// Scoreboarded bench for vga_sync_rx on a reduced 40x12 timing: pixels and frame_start checked from queues.
module tb_vga_sync_rx;

  localparam int HT = 40;
  localparam int VT = 12;
  localparam int HA = 24;
  localparam int VA = 8;
  localparam int HS = 6;
  localparam int HBP = 4;
  localparam int VS_LINES = 2;
  localparam int VSTART = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsync, vsync, blank_b;
  logic [7:0]  r, g, b;
  logic        pix_valid;
  logic [9:0]  pix_x, pix_y;
  logic [23:0] pix_rgb;
  logic        frame_start;
  logic [9:0]  line_len, frame_lines;
  logic        locked, err;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
  } pix_t;

  typedef struct packed {
    logic chk;
    logic lk;
    logic er;
  } fs_t;

  pix_t pix_q[$];
  fs_t  fs_q[$];
  pix_t pe;
  fs_t  fe;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  vga_sync_rx #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .blank_b(blank_b),
    .r(r), .g(g), .b(b),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .line_len(line_len), .frame_lines(frame_lines),
    .locked(locked), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every DUT output event consumes the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (pix_valid) begin
        if (pix_q.size() == 0) begin
          check("pix_unexpected", 32'(pix_valid), 32'd0);
        end else begin
          pe = pix_q.pop_front();
          check("pix_x", 32'(pix_x), 32'(pe.x));
          check("pix_y", 32'(pix_y), 32'(pe.y));
          check("pix_rgb", 32'(pix_rgb), 32'(pe.rgb));
        end
      end
      if (frame_start) begin
        if (fs_q.size() == 0) begin
          check("fs_unexpected", 32'(frame_start), 32'd0);
        end else begin
          fe = fs_q.pop_front();
          if (fe.chk) begin
            check("frame_lines", 32'(frame_lines), VT);
            check("line_len", 32'(line_len), HT);
          end
          check("fs_locked", 32'(locked), 32'(fe.lk));
          check("fs_err", 32'(err), 32'(fe.er));
          check("fs_vcnt", 32'(dut.vcnt), 32'd0);
        end
      end
    end
  end

  task automatic push_fs(input logic chk, input logic lk, input logic er);
    fs_t e;
    e.chk = chk;
    e.lk  = lk;
    e.er  = er;
    fs_q.push_back(e);
  endtask

  task automatic cyc(input logic hs, input logic vs, input logic bl, input logic [23:0] rgb);
    hsync   = hs;
    vsync   = vs;
    blank_b = bl;
    {r, g, b} = rgb;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_pix_x"}, 32'(pix_x), 32'd0);
    check({tag, "_pix_y"}, 32'(pix_y), 32'd0);
    check({tag, "_pix_rgb"}, 32'(pix_rgb), 32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check({tag, "_line_len"}, 32'(line_len), 32'd0);
    check({tag, "_frame_lines"}, 32'(frame_lines), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // One frame; vsync falls with line 0's hsync. short_line drops one front-porch clock.
  task automatic gen_frame(input int fid, input int short_line, input int abort_line);
    int          len, x, y;
    logic        act;
    logic [23:0] rgb;
    pix_t        e;
    for (int l = 0; l < VT; l++) begin
      len = (l == short_line) ? HT - 1 : HT;
      for (int c = 0; c < len; c++) begin
        if (l == abort_line && c == 20) return;
        act = (l >= VSTART) && (l < VSTART + VA) && (c >= HS + HBP) && (c < HS + HBP + HA);
        x = c - (HS + HBP);
        y = l - VSTART;
        rgb = (x == 0 && y == 0) ? 24'h123456 : {8'(x), 8'(y), 8'(fid)};
        if (act) begin
          e.x = 10'(x);
          e.y = 10'(y);
          e.rgb = rgb;
          pix_q.push_back(e);
        end
        cyc(c >= HS, l >= VS_LINES, act, act ? rgb : 24'h0);
        if (short_line >= 0 && l == short_line + 1 && c == 0) check("lock_hold", 32'(locked), 32'd1);
        if (short_line >= 0 && l == short_line + 1 && c == 1) begin
          check("lock_drop", 32'(locked), 32'd0);
          check("err_set", 32'(err), 32'd1);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    hsync = 1'b1; vsync = 1'b1; blank_b = 1'b0;
    r = 8'h0; g = 8'h0; b = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst = 1'b1;
    repeat (5) cyc(1'b1, 1'b1, 1'b0, 24'h0);

    push_fs(1'b0, 1'b0, 1'b0); gen_frame(1, -1, -1);
    push_fs(1'b1, 1'b0, 1'b0); gen_frame(2, -1, -1);
    push_fs(1'b1, 1'b1, 1'b0); gen_frame(3, 5, -1);
    push_fs(1'b1, 1'b0, 1'b1); gen_frame(4, -1, -1);
    push_fs(1'b1, 1'b0, 1'b1); gen_frame(5, -1, -1);
    push_fs(1'b1, 1'b1, 1'b1); gen_frame(6, -1, 5);

    repeat (4) cyc(1'b1, 1'b1, 1'b0, 24'h0);
    rst = 1'b0;
    #1;
    check_reset("arst");
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 24'h0);
    check("rst_hold_fs", 32'(frame_start), 32'd0);
    check("rst_hold_state", 32'(dut.state), 32'd0);
    rst = 1'b1;
    repeat (6) cyc(1'b1, 1'b1, 1'b0, 24'h0);
    check("post_rst_locked", 32'(locked), 32'd0);
    check("post_rst_err", 32'(err), 32'd0);

    push_fs(1'b0, 1'b0, 1'b0); gen_frame(7, -1, -1);
    push_fs(1'b1, 1'b0, 1'b0); gen_frame(8, -1, -1);
    push_fs(1'b1, 1'b1, 1'b0); gen_frame(9, -1, -1);

    repeat (2000) cyc(1'b1, 1'b1, 1'b0, 24'h0);
    check("hcnt_sat", 32'(dut.hcnt), 32'd1023);
    check("hold_line_len", 32'(line_len), HT);
    check("hold_locked", 32'(locked), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 24'h0);
    cyc(1'b0, 1'b1, 1'b0, 24'h0);
    check("long_line_len", 32'(line_len), 32'd1023);
    check("long_locked", 32'(locked), 32'd0);
    check("long_err", 32'(err), 32'd1);
    repeat (6) cyc(1'b1, 1'b1, 1'b0, 24'h0);

    check("pix_q_drained", 32'(pix_q.size()), 32'd0);
    check("fs_q_drained", 32'(fs_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
